// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter in front of a shared bitwise logic unit.
// One op is accepted per cycle; the result is held until the consumer takes it.
module logic_unit_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [2*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_a,
  input  logic [WIDTH*NUM_REQ-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [WIDTH-1:0]         resp_data,
  output logic [1:0]               resp_id,
  output logic [15:0]              grant_count
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t           state_q;
  logic             resp_valid_q;
  logic [WIDTH-1:0] resp_data_q;
  logic [1:0]       resp_id_q;
  logic [1:0]       rr_ptr_q;
  logic [15:0]      grant_count_q;

  logic             can_accept;
  logic             win_found;
  logic [1:0]       win_idx;
  logic             accept;
  logic [1:0]       op_sel;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH-1:0] result_d;
  logic [15:0]      grant_count_d;

  function automatic logic [WIDTH-1:0] lu_op(input logic [1:0] op,
                                             input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    case (op)
      2'b00:   lu_op = a & b;
      2'b01:   lu_op = a | b;
      2'b10:   lu_op = a ^ b;
      default: lu_op = a & ~b;
    endcase
  endfunction

  // Accepting is allowed while empty, or while the held result is drained this cycle.
  assign can_accept = rst_n & ((state_q == IDLE) | resp_ready);

  always_comb begin
    logic [1:0] cand;
    cand      = '0;
    win_found = 1'b0;
    win_idx   = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = rr_ptr_q + 2'(k);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign accept = can_accept & win_found;

  always_comb begin
    req_ready = '0;
    if (accept) req_ready[win_idx] = 1'b1;
  end

  assign op_sel        = req_op[{win_idx, 1'b0} +: 2];
  assign a_sel         = req_a[WIDTH*win_idx +: WIDTH];
  assign b_sel         = req_b[WIDTH*win_idx +: WIDTH];
  assign result_d      = lu_op(op_sel, a_sel, b_sel);
  assign grant_count_d = (grant_count_q == 16'hFFFF) ? grant_count_q : grant_count_q + 16'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      resp_valid_q  <= 1'b0;
      resp_data_q   <= '0;
      resp_id_q     <= '0;
      rr_ptr_q      <= '0;
      grant_count_q <= '0;
    end else if (accept) begin
      state_q       <= HOLD;
      resp_valid_q  <= 1'b1;
      resp_data_q   <= result_d;
      resp_id_q     <= win_idx;
      rr_ptr_q      <= win_idx + 2'd1;
      grant_count_q <= grant_count_d;
    end else if (state_q == HOLD && resp_ready) begin
      state_q      <= IDLE;
      resp_valid_q <= 1'b0;
    end
  end

  assign resp_valid  = resp_valid_q;
  assign resp_data   = resp_data_q;
  assign resp_id     = resp_id_q;
  assign grant_count = grant_count_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed and random checks of logic_unit_arbiter against a behavioural model.
module tb_logic_unit_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [2*N-1:0] req_op;
  logic [W*N-1:0] req_a;
  logic [W*N-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           resp_valid;
  logic           resp_ready;
  logic [W-1:0]   resp_data;
  logic [1:0]     resp_id;
  logic [15:0]    grant_count;

  logic [1:0]   t_op[N];
  logic [W-1:0] t_a[N];
  logic [W-1:0] t_b[N];

  int checks = 0;
  int errors = 0;
  bit checking = 1'b1;

  // Behavioural reference state
  bit           m_valid;
  logic [W-1:0] m_data;
  int           m_id, m_ptr, m_count;

  logic_unit_arbiter #(.NUM_REQ(N), .WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .resp_id(resp_id), .grant_count(grant_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return a & ~b;
    endcase
  endfunction

  task automatic pack();
    for (int i = 0; i < N; i++) begin
      req_op[2*i +: 2] = t_op[i];
      req_a[W*i +: W]  = t_a[i];
      req_b[W*i +: W]  = t_b[i];
    end
  endtask

  // One clock: check req_ready before the edge, advance the model, check outputs after.
  task automatic cycle();
    logic [N-1:0] er;
    int  w;
    bit  can;
    pack();
    #1;
    can = (rst_n === 1'b1) && (!m_valid || resp_ready);
    w = -1;
    for (int k = 0; k < N; k++)
      if (w < 0 && req_valid[(m_ptr + k) % N]) w = (m_ptr + k) % N;
    er = '0;
    if (can && w >= 0) er[w] = 1'b1;
    if (checking) chk("req_ready", 64'(req_ready), 64'(er));
    if (rst_n !== 1'b1) begin
      m_valid = 0; m_data = '0; m_id = 0; m_ptr = 0; m_count = 0;
    end else if (can && w >= 0) begin
      m_data  = ref_op(t_op[w], t_a[w], t_b[w]);
      m_id    = w;
      m_valid = 1;
      m_ptr   = (w + 1) % N;
      m_count = (m_count < 65535) ? m_count + 1 : 65535;
    end else if (m_valid && resp_ready) begin
      m_valid = 0;
    end
    @(posedge clk);
    #1;
    if (checking) begin
      chk("resp_valid", 64'(resp_valid), 64'(m_valid));
      chk("resp_data", 64'(resp_data), 64'(m_data));
      chk("resp_id", 64'(resp_id), 64'(m_id));
      chk("grant_count", 64'(grant_count), 64'(m_count));
    end
  endtask

  task automatic clear_req();
    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      t_op[i] = '0; t_a[i] = '0; t_b[i] = '0;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  initial begin
    int order[5];
    order = '{0, 1, 2, 3, 0};
    m_valid = 0; m_data = '0; m_id = 0; m_ptr = 0; m_count = 0;
    rst_n = 1'b0; resp_ready = 1'b1;
    clear_req();
    @(posedge clk); #1;
    do_reset();
    chk("reset_valid", 64'(resp_valid), 64'd0);
    chk("reset_data", 64'(resp_data), 64'd0);
    chk("reset_count", 64'(grant_count), 64'd0);

    // Single request
    req_valid = 4'b0001; t_op[0] = 2'b00; t_a[0] = 32'hFFFF0000; t_b[0] = 32'h0F0F0F0F;
    cycle();
    chk("single_data", 64'(resp_data), 64'h0F0F0000);
    chk("single_id", 64'(resp_id), 64'd0);
    chk("single_count", 64'(grant_count), 64'd1);
    req_valid = '0;
    cycle();
    chk("single_drain", 64'(resp_valid), 64'd0);

    // All opcodes back to back
    req_valid = 4'b0001; t_a[0] = 32'h0000000C; t_b[0] = 32'h0000000A;
    t_op[0] = 2'b00; cycle(); chk("op_and", 64'(resp_data), 64'h8);
    t_op[0] = 2'b01; cycle(); chk("op_or", 64'(resp_data), 64'hE);
    t_op[0] = 2'b10; cycle(); chk("op_xor", 64'(resp_data), 64'h6);
    t_op[0] = 2'b11; cycle(); chk("op_andn", 64'(resp_data), 64'h4);

    // Fairness from pointer 0
    do_reset();
    req_valid = 4'b1111;
    for (int i = 0; i < N; i++) begin
      t_op[i] = 2'(i); t_a[i] = $urandom; t_b[i] = $urandom;
    end
    for (int k = 0; k < 5; k++) begin
      pack(); #1;
      chk("fair_ready", 64'(req_ready), 64'(1 << order[k]));
      cycle();
      chk("fair_id", 64'(resp_id), 64'(order[k]));
    end

    // Backpressure: result pending, consumer stalls three cycles
    resp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("bp_ready", 64'(req_ready), 64'd0);
      chk("bp_valid", 64'(resp_valid), 64'd1);
    end
    req_valid = '0; resp_ready = 1'b1;
    cycle();
    chk("bp_drain", 64'(resp_valid), 64'd0);

    // Reset while holding a result
    req_valid = 4'b0100; resp_ready = 1'b0;
    cycle();
    chk("hold_before_rst", 64'(resp_valid), 64'd1);
    rst_n = 1'b0; req_valid = 4'b1111;
    pack(); #1;
    chk("rst_ready", 64'(req_ready), 64'd0);
    cycle();
    rst_n = 1'b1;
    chk("rst_valid", 64'(resp_valid), 64'd0);
    chk("rst_count", 64'(grant_count), 64'd0);
    req_valid = 4'b1010; resp_ready = 1'b1;
    pack(); #1;
    chk("rst_first_grant", 64'(req_ready), 64'b0010);
    cycle();

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      req_valid  = 4'($urandom);
      resp_ready = ($urandom_range(0, 3) != 0);
      rst_n      = ($urandom_range(0, 40) != 0);
      for (int i = 0; i < N; i++) begin
        t_op[i] = 2'($urandom); t_a[i] = $urandom; t_b[i] = $urandom;
      end
      cycle();
    end
    rst_n = 1'b1;

    // Saturation of grant_count
    do_reset();
    clear_req();
    req_valid = 4'b0001; resp_ready = 1'b1;
    checking = 1'b0;
    for (int n = 0; n < 65534; n++) cycle();
    checking = 1'b1;
    chk("sat_fffe", 64'(grant_count), 64'hFFFE);
    cycle();
    chk("sat_ffff", 64'(grant_count), 64'hFFFF);
    cycle();
    chk("sat_hold", 64'(grant_count), 64'hFFFF);
    cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/logic_unit_arbiter.md
LOGIC_UNIT_ARBITER -- requirements
Module: logic_unit_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, the number of requesters sharing the logic unit (fixed at 4 for this revision).
REQ-002 SHALL have parameter WIDTH, default 32, the operand and result width in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-005 SHALL have port req_valid, input, NUM_REQ, per-requester operation-valid flags.
REQ-006 SHALL have port req_op, input, 2*NUM_REQ, per-requester opcode packed as {op3,op2,op1,op0}.
REQ-007 SHALL have port req_a, input, WIDTH*NUM_REQ, per-requester operand A, packed with requester 0 in the LSBs.
REQ-008 SHALL have port req_b, input, WIDTH*NUM_REQ, per-requester operand B, packed the same as req_a.
REQ-009 SHALL have port req_ready, output, NUM_REQ, one-hot or zero accept strobe per requester.
REQ-010 SHALL have port resp_valid, output, 1, result-valid flag.
REQ-011 SHALL have port resp_ready, input, 1, consumer accepts the result.
REQ-012 SHALL have port resp_data, output, WIDTH, registered result.
REQ-013 SHALL have port resp_id, output, 2, index of the requester that owns resp_data.
REQ-014 SHALL have port grant_count, output, 16, saturating count of accepted operations.

Function
REQ-015 SHALL define opcodes as 00 = A AND B, 01 = A OR B, 10 = A XOR B, 11 = A AND (NOT B), all bitwise over WIDTH bits.
REQ-016 SHALL implement a two-state FSM: IDLE (no result held) and HOLD (resp_valid=1, result held).
REQ-017 SHALL define can_accept as (state==IDLE) or (state==HOLD and resp_ready==1).
REQ-018 SHALL select the winner by round-robin: scan rr_ptr, rr_ptr+1, ... mod 4, and pick the first index with req_valid set.
REQ-019 SHALL drive req_ready combinationally as one-hot on the winner when can_accept is 1, and all-zero otherwise.
REQ-020 SHALL define acceptance as req_valid[i] and req_ready[i] in the same cycle, with at most one acceptance per cycle.
REQ-021 SHALL, on acceptance, register the op result into resp_data and i into resp_id, set resp_valid, enter HOLD, set rr_ptr to (i+1) mod 4, and increment grant_count; latency is 1 cycle from accept to resp_valid.
REQ-022 SHALL, in HOLD with resp_ready=1 and no acceptance, clear resp_valid and return to IDLE.
REQ-023 SHALL, in HOLD with resp_ready=1 and a new acceptance in the same cycle, stay in HOLD and load the new result, giving back-to-back throughput of 1 op per cycle.
REQ-024 SHALL, in HOLD with resp_ready=0, hold resp_data, resp_id and resp_valid stable and keep req_ready all-zero.
REQ-025 SHALL leave rr_ptr unchanged in any cycle without an acceptance.
REQ-026 SHALL saturate grant_count at 16'hFFFF with no wrap.
REQ-027 SHALL ignore req_op, req_a and req_b of requesters that are not granted.

Reset
REQ-028 SHALL, when rst_n is sampled 0, set state=IDLE, resp_valid=0, resp_data=0, resp_id=0, rr_ptr=0 and grant_count=0.
REQ-029 SHALL force req_ready to all-zero during any cycle in which rst_n=0.
REQ-030 SHALL, on a reset asserted mid-HOLD, discard the held result without a handshake; the next cycle shows resp_valid=0.

Verification
REQ-031 SHALL cover single request: req_valid=0001, op=00, A=FFFF0000, B=0F0F0F0F, resp_ready=1 -> next cycle resp_valid=1, resp_data=0F0F0000, resp_id=0, grant_count=1.
REQ-032 SHALL cover fairness: all four requesters held valid with resp_ready=1 -> grants in order 0,1,2,3,0 on consecutive cycles, and resp_id follows 1 cycle later.
REQ-033 SHALL cover backpressure: result pending with resp_ready=0 for 3 cycles -> resp_data stable, req_ready=0000, and after resp_ready=1 the held result is consumed in 1 cycle.
REQ-034 SHALL cover all opcodes: A=0000000C, B=0000000A, ops 00/01/10/11 -> results 8, E, 6, 4.
REQ-035 SHALL cover reset mid-HOLD: rst_n=0 for 1 cycle while resp_valid=1 -> resp_valid=0, grant_count=0, and the first grant after reset goes to the lowest valid index scanning from 0.
REQ-036 SHALL cover saturation: preload grant_count to FFFE via 2 extra accepts over the 65534-accept sequence -> grant_count reads FFFF and stays FFFF.
